// File: rtl/opl_pkg.sv
// Shared constants and types for the OPL write queue: bus timing defaults,
// the queued register pair, and the issue FSM state encoding.
package opl_pkg;
  localparam int OPL2_ADDR_WAIT = 12;
  localparam int OPL2_DATA_WAIT = 84;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } opl_pair_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT_A,
    ST_DATA,
    ST_WAIT_D
  } opl_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers, show-ahead read data and
// registered full/empty flags. Overflowing pushes and underflowing pops are ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             r_full, r_empty;
  logic             w_push_ok, w_pop_ok;
  logic [AW:0]      w_count_nxt;

  assign w_push_ok   = i_push && !r_full;
  assign w_pop_ok    = i_pop && !r_empty;
  assign w_count_nxt = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;
endmodule

// File: rtl/opl_write_queue.sv
// Pairs incoming bytes into OPL register address/data writes, queues them and
// replays them on the OPL bus with the chip's mandatory address and data recovery gaps.
module opl_write_queue
  import opl_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_WAIT = OPL2_ADDR_WAIT,
  parameter int DATA_WAIT = OPL2_DATA_WAIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_eop,
  output logic       out_cs_n,
  output logic       out_wr_n,
  output logic       out_addr,
  output logic [7:0] out_din,
  output logic       fifo_full,
  output logic       overflow,
  output logic       busy
);
  localparam int FCW  = $clog2(DEPTH) + 1;
  localparam int WMAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int TW   = $clog2(WMAX);

  logic            r_phase;
  logic [7:0]      r_pend;
  logic            r_overflow;
  opl_state_t      r_state;
  logic [TW-1:0]   r_cnt;
  logic [7:0]      r_data;
  logic            r_cs_n, r_addr, r_busy;
  logic [7:0]      r_din;

  logic            w_phase_eff, w_push, w_push_ok, w_pop;
  logic            w_last_wd, w_idle_nxt;
  opl_pair_t       w_wdata, w_rdata;
  logic            w_full, w_empty;
  logic [FCW-1:0]  w_count, w_count_nxt;

  // eop takes effect before a same-cycle byte, so that byte starts a new pair
  assign w_phase_eff = in_eop ? 1'b0 : r_phase;
  assign w_push      = in_valid && w_phase_eff;
  assign w_push_ok   = w_push && !w_full;
  assign w_wdata     = '{addr: r_pend, data: in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= 1'b0;
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        if (!w_phase_eff) begin
          r_pend  <= in_data;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
        end
      end else if (in_eop) begin
        r_phase <= 1'b0;
      end
      if (w_push && w_full) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(opl_pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_last_wd   = (r_state == ST_WAIT_D) && (r_cnt == '0);
  assign w_pop       = ((r_state == ST_IDLE) || w_last_wd) && !w_empty;
  assign w_idle_nxt  = ((r_state == ST_IDLE) || w_last_wd) && w_empty;
  assign w_count_nxt = w_count + FCW'(w_push_ok) - FCW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_cs_n  <= 1'b1;
      r_addr  <= 1'b0;
      r_din   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= !w_idle_nxt || (w_count_nxt != '0);
      case (r_state)
        ST_IDLE, ST_WAIT_D: begin
          if (r_state == ST_WAIT_D && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!w_empty) begin
            r_data  <= w_rdata.data;
            r_din   <= w_rdata.addr;
            r_addr  <= 1'b0;
            r_cs_n  <= 1'b0;
            r_state <= ST_ADDR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          r_cs_n  <= 1'b1;
          r_cnt   <= TW'(ADDR_WAIT - 2);
          r_state <= ST_WAIT_A;
        end
        ST_WAIT_A: begin
          if (r_cnt == '0) begin
            r_cs_n  <= 1'b0;
            r_addr  <= 1'b1;
            r_din   <= r_data;
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          r_cs_n  <= 1'b1;
          r_cnt   <= TW'(DATA_WAIT - 2);
          r_state <= ST_WAIT_D;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_cs_n  = r_cs_n;
  assign out_wr_n  = r_cs_n;
  assign out_addr  = r_addr;
  assign out_din   = r_din;
  assign fifo_full = w_full;
  assign overflow  = r_overflow;
  assign busy      = r_busy;
endmodule

// File: tb/tb_opl_write_queue.sv
// Bench for opl_write_queue: an event-level model predicts every pulse time,
// FIFO occupancy and busy window, checked each cycle; directed scenarios pin it.
module tb_opl_write_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 12;
  localparam int DW    = 84;
  localparam int PER   = AW + DW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_eop = 1'b0;
  logic       out_cs_n, out_wr_n, out_addr, fifo_full, overflow, busy;
  logic [7:0] out_din;

  always #5 clk = ~clk;

  opl_write_queue #(.DEPTH(DEPTH), .ADDR_WAIT(AW), .DATA_WAIT(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_eop(in_eop),
    .out_cs_n(out_cs_n), .out_wr_n(out_wr_n), .out_addr(out_addr), .out_din(out_din),
    .fifo_full(fifo_full), .overflow(overflow), .busy(busy)
  );

  // one accepted pair: push edge n (end of cycle n), address pulse cycle a
  typedef struct { int n; int a; logic [7:0] ad; logic [7:0] da; } ent_t;
  ent_t q[$];

  int         cyc = 0;
  int         checks = 0, errors = 0;
  bit         m_phase;
  logic [7:0] m_pend;
  bit         m_ovf;
  int         m_ovf_at;
  logic [7:0] last_din;
  logic       last_addr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_phase = 0; m_pend = 8'h00; m_ovf = 0; m_ovf_at = 0;
    last_din = 8'h00; last_addr = 1'b0;
  endtask

  task automatic model_push(input int n, input logic [7:0] ad, input logic [7:0] da);
    int occ;
    ent_t e;
    occ = 0;
    foreach (q[i]) if (q[i].n < n && q[i].a - 1 >= n) occ++;
    if (occ >= DEPTH) begin
      if (!m_ovf) begin m_ovf = 1; m_ovf_at = n + 1; end
    end else begin
      e.n = n; e.ad = ad; e.da = da;
      e.a = n + 2;
      if (q.size() > 0 && q[$].a + PER > e.a) e.a = q[$].a + PER;
      q.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_eop) m_phase = 0;
      if (in_valid) begin
        if (!m_phase) begin m_pend = in_data; m_phase = 1; end
        else begin m_phase = 0; model_push(cyc, m_pend, in_data); end
      end
    end
    cyc = cyc + 1;
  end

  logic       e_cs, e_addr, e_busy;
  logic [7:0] e_din;
  int         e_occ;
  always @(negedge clk) begin
    if (rst_n) begin
      e_cs = 1'b1; e_din = last_din; e_addr = last_addr; e_occ = 0; e_busy = 1'b0;
      foreach (q[i]) begin
        if (q[i].a == cyc)      begin e_cs = 1'b0; e_din = q[i].ad; e_addr = 1'b0; end
        if (q[i].a + AW == cyc) begin e_cs = 1'b0; e_din = q[i].da; e_addr = 1'b1; end
        if (q[i].n < cyc && cyc <= q[i].a - 1)       e_occ++;
        if (q[i].n < cyc && cyc <= q[i].a + PER - 1) e_busy = 1'b1;
      end
      last_din = e_din; last_addr = e_addr;
      chk("cs_n", out_cs_n, e_cs);
      chk("wr_n", out_wr_n, e_cs);
      chk("addr", out_addr, e_addr);
      chk("din", out_din, e_din);
      chk("fifo_full", fifo_full, e_occ == DEPTH);
      chk("busy", busy, e_busy);
      chk("overflow", overflow, m_ovf && cyc >= m_ovf_at);
    end
  end

  task automatic idle_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      in_valid = 1'b0; in_eop = 1'b0;
    end
  endtask

  task automatic drive_at(input int t, input logic v, input logic [7:0] d, input logic e);
    idle_to(t - 1);
    @(negedge clk);
    in_valid = v; in_data = d; in_eop = e;
  endtask

  int t0;
  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_cs_n", out_cs_n, 1); chk("rst_wr_n", out_wr_n, 1);
    chk("rst_addr", out_addr, 0); chk("rst_din", out_din, 0);
    chk("rst_full", fifo_full, 0); chk("rst_ovf", overflow, 0); chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic latency and address-to-data spacing
    t0 = cyc;
    drive_at(t0 + 10, 1, 8'hA0, 0);
    drive_at(t0 + 20, 1, 8'h57, 0);
    idle_to(t0 + 22);
    chk("lat_a_cs", out_cs_n, 0); chk("lat_a_din", out_din, 8'hA0); chk("lat_a_addr", out_addr, 0);
    idle_to(t0 + 23);
    chk("hold_cs", out_cs_n, 1); chk("hold_din", out_din, 8'hA0);
    idle_to(t0 + 34);
    chk("lat_d_cs", out_cs_n, 0); chk("lat_d_din", out_din, 8'h57); chk("lat_d_addr", out_addr, 1);
    idle_to(t0 + 130);

    // three pairs back to back
    t0 = cyc;
    drive_at(t0 + 1, 1, 8'h01, 0); drive_at(t0 + 2, 1, 8'h11, 0);
    drive_at(t0 + 3, 1, 8'h02, 0); drive_at(t0 + 4, 1, 8'h22, 0);
    drive_at(t0 + 5, 1, 8'h03, 0); drive_at(t0 + 6, 1, 8'h33, 0);
    idle_to(t0 + 100);
    chk("b2b_a2_cs", out_cs_n, 0); chk("b2b_a2_din", out_din, 8'h02);
    idle_to(t0 + 208);
    chk("b2b_d3_din", out_din, 8'h33);
    idle_to(t0 + 291);
    chk("b2b_busy_hi", busy, 1);
    idle_to(t0 + 292);
    chk("b2b_busy_lo", busy, 0);
    idle_to(t0 + 300);

    // eop discards a pending address byte
    t0 = cyc;
    drive_at(t0 + 1, 1, 8'hB0, 0);
    drive_at(t0 + 2, 0, 8'h00, 1);
    drive_at(t0 + 3, 1, 8'h20, 0);
    drive_at(t0 + 4, 1, 8'h11, 0);
    idle_to(t0 + 6);
    chk("eop_a_din", out_din, 8'h20); chk("eop_a_cs", out_cs_n, 0);
    idle_to(t0 + 18);
    chk("eop_d_din", out_din, 8'h11);
    idle_to(t0 + 110);

    // byte and eop together start a new pair
    t0 = cyc;
    drive_at(t0 + 1, 1, 8'h60, 1);
    drive_at(t0 + 2, 1, 8'h0F, 0);
    idle_to(t0 + 4);
    chk("veop_a_din", out_din, 8'h60); chk("veop_a_cs", out_cs_n, 0);
    idle_to(t0 + 16);
    chk("veop_d_din", out_din, 8'h0F); chk("veop_d_addr", out_addr, 1);
    idle_to(t0 + 110);

    // reset during WAIT_A abandons the pair
    t0 = cyc;
    drive_at(t0 + 1, 1, 8'h40, 0);
    drive_at(t0 + 2, 1, 8'h3F, 0);
    idle_to(t0 + 8);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_cs", out_cs_n, 1); chk("mid_rst_din", out_din, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_addr", out_addr, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle_to(t0 + 16);
    chk("mid_rst_no_data", out_cs_n, 1);
    drive_at(t0 + 20, 1, 8'h41, 0);
    drive_at(t0 + 21, 1, 8'h42, 0);
    idle_to(t0 + 23);
    chk("post_rst_a_din", out_din, 8'h41); chk("post_rst_a_cs", out_cs_n, 0);
    idle_to(t0 + 130);

    // fill the FIFO while the first write occupies the bus
    t0 = cyc;
    for (int i = 0; i < 18; i++) begin
      drive_at(t0 + 1 + 2*i, 1, 8'h80 + 8'(i), 0);
      drive_at(t0 + 2 + 2*i, 1, 8'(i), 0);
    end
    idle_to(t0 + 37);
    chk("fill_full", fifo_full, 1); chk("fill_ovf", overflow, 1);
    idle_to(t0 + 17*PER + 20);
    chk("drain_full", fifo_full, 0); chk("drain_ovf_sticky", overflow, 1);

    // randomized traffic from a clean state
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 3);
      in_data  = 8'($urandom_range(0, 255));
      in_eop   = ($urandom_range(0, 29) == 0);
    end
    idle_to(cyc + DEPTH*PER + 2*PER);
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
